// File: rtl/i2c_unit_if.sv
// Command/response bundle between a register front-end and the i2c_unit byte-level master.
// The front-end (requester) takes the master modport; the bus engine takes the slave modport.
interface i2c_unit_if;
   logic [1:0] i2cCommand;
   logic [7:0] i2cWriteData;
   logic       i2cWriteAck;
   logic       i2cTransactionValid;
   logic [7:0] i2cReadData;
   logic       i2cReadAck;
   logic       i2cBusy;
   logic       i2cWriteDataAck;
   logic       i2cReadDataValid;

   modport master (
      output i2cCommand,
      output i2cWriteData,
      output i2cWriteAck,
      output i2cTransactionValid,
      input  i2cReadData,
      input  i2cReadAck,
      input  i2cBusy,
      input  i2cWriteDataAck,
      input  i2cReadDataValid
   );

   modport slave (
      input  i2cCommand,
      input  i2cWriteData,
      input  i2cWriteAck,
      input  i2cTransactionValid,
      output i2cReadData,
      output i2cReadAck,
      output i2cBusy,
      output i2cWriteDataAck,
      output i2cReadDataValid
   );
endinterface

// File: rtl/i2c_unit.sv
// Byte-level I2C master: START, STOP, TRANSMIT and RECEIVE on open-drain SCL/SDA,
// every bus action paced by the external quarter-bit tick cycleDone.
module i2c_unit (
   input  logic      clk,
   input  logic      reset,
   input  logic      cycleDone,
   i2c_unit_if.slave bus,
   inout  wire       i2cScl,
   inout  wire       i2cSda
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      STOP  = 2'd2,
      BIT   = 2'd3
   } state_t;

   localparam logic [1:0] CMD_START = 2'b00;
   localparam logic [1:0] CMD_STOP  = 2'b01;
   localparam logic [1:0] CMD_TX    = 2'b10;
   localparam logic [3:0] ACK_BIT   = 4'd8;

   state_t     state, stateNext;
   logic [1:0] quarter, quarterNext;
   logic [3:0] bitCnt, bitCntNext;
   logic       isRx, isRxNext;
   logic [7:0] txShift, txShiftNext;
   logic [7:0] rxShift, rxShiftNext;
   logic       ackOut, ackOutNext;
   logic       sclLow, sclLowNext;
   logic       sdaLow, sdaLowNext;
   logic [7:0] readData, readDataNext;
   logic       readAck, readAckNext;
   logic       wdAck, wdAckNext;
   logic       rdValid, rdValidNext;
   logic       sdaIn;

   // SDA pull-down for the data phase of a bit: data bits on transmit, the ACK bit on receive.
   function automatic logic bitDrive(input logic rx, input logic [3:0] bitIdx,
                                     input logic txBit, input logic ack);
      if (bitIdx == ACK_BIT) return rx ? ~ack : 1'b0;
      return rx ? 1'b0 : ~txBit;
   endfunction

   assign i2cScl = sclLow ? 1'b0 : 1'bz;
   assign i2cSda = sdaLow ? 1'b0 : 1'bz;
   assign sdaIn  = i2cSda;

   assign bus.i2cReadData      = readData;
   assign bus.i2cReadAck       = readAck;
   assign bus.i2cBusy          = (state != IDLE);
   assign bus.i2cWriteDataAck  = wdAck;
   assign bus.i2cReadDataValid = rdValid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         quarter  <= 2'd0;
         bitCnt   <= 4'd0;
         isRx     <= 1'b0;
         txShift  <= 8'h00;
         rxShift  <= 8'h00;
         ackOut   <= 1'b1;
         sclLow   <= 1'b0;
         sdaLow   <= 1'b0;
         readData <= 8'h00;
         readAck  <= 1'b1;
         wdAck    <= 1'b0;
         rdValid  <= 1'b0;
      end else begin
         state    <= stateNext;
         quarter  <= quarterNext;
         bitCnt   <= bitCntNext;
         isRx     <= isRxNext;
         txShift  <= txShiftNext;
         rxShift  <= rxShiftNext;
         ackOut   <= ackOutNext;
         sclLow   <= sclLowNext;
         sdaLow   <= sdaLowNext;
         readData <= readDataNext;
         readAck  <= readAckNext;
         wdAck    <= wdAckNext;
         rdValid  <= rdValidNext;
      end
   end

   always_comb begin
      stateNext    = state;
      quarterNext  = quarter;
      bitCntNext   = bitCnt;
      isRxNext     = isRx;
      txShiftNext  = txShift;
      rxShiftNext  = rxShift;
      ackOutNext   = ackOut;
      sclLowNext   = sclLow;
      sdaLowNext   = sdaLow;
      readDataNext = readData;
      readAckNext  = readAck;
      wdAckNext    = 1'b0;
      rdValidNext  = 1'b0;

      if (cycleDone) begin
         case (state)
            IDLE: begin
               // The accepting tick is quarter 0 of the new command and executes it.
               if (bus.i2cTransactionValid) begin
                  quarterNext = 2'd1;
                  bitCntNext  = 4'd0;
                  isRxNext    = (bus.i2cCommand == 2'b11);
                  txShiftNext = bus.i2cWriteData;
                  ackOutNext  = bus.i2cWriteAck;
                  case (bus.i2cCommand)
                     CMD_START: begin
                        stateNext  = START;
                        sdaLowNext = 1'b0;
                     end
                     CMD_STOP: begin
                        stateNext  = STOP;
                        sdaLowNext = 1'b1;
                     end
                     CMD_TX: begin
                        stateNext  = BIT;
                        sdaLowNext = bitDrive(1'b0, 4'd0, bus.i2cWriteData[7], 1'b1);
                        wdAckNext  = 1'b1;
                     end
                     default: begin
                        stateNext  = BIT;
                        sdaLowNext = 1'b0;
                     end
                  endcase
               end
            end

            START: begin
               quarterNext = quarter + 2'd1;
               case (quarter)
                  2'd1:    sclLowNext = 1'b0;
                  2'd2:    sdaLowNext = 1'b1;
                  default: begin
                     sclLowNext = 1'b1;
                     stateNext  = IDLE;
                  end
               endcase
            end

            STOP: begin
               quarterNext = quarter + 2'd1;
               case (quarter)
                  2'd1:    sclLowNext = 1'b0;
                  2'd2:    sdaLowNext = 1'b0;
                  default: stateNext  = IDLE;
               endcase
            end

            default: begin
               quarterNext = quarter + 2'd1;
               case (quarter)
                  2'd0: sdaLowNext = bitDrive(isRx, bitCnt, txShift[7], ackOut);
                  2'd1: sclLowNext = 1'b0;
                  2'd2: begin
                     if (bitCnt == ACK_BIT) begin
                        if (!isRx) readAckNext = sdaIn;
                     end else if (isRx) begin
                        rxShiftNext = {rxShift[6:0], sdaIn};
                     end
                  end
                  default: begin
                     sclLowNext  = 1'b1;
                     txShiftNext = {txShift[6:0], 1'b0};
                     if (bitCnt == ACK_BIT) begin
                        stateNext = IDLE;
                        if (isRx) begin
                           readDataNext = rxShift;
                           rdValidNext  = 1'b1;
                        end
                     end else begin
                        bitCntNext = bitCnt + 4'd1;
                     end
                  end
               endcase
            end
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_unit.sv
// Randomized bench for i2c_unit: drives commands through the interface against a 24LC00-style
// EEPROM bus model, with a bus monitor and an expected-memory model for the data checks.
module tb_i2c_unit;
   localparam logic [1:0] CMD_START = 2'b00;
   localparam logic [1:0] CMD_STOP  = 2'b01;
   localparam logic [1:0] CMD_TX    = 2'b10;
   localparam logic [1:0] CMD_RX    = 2'b11;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic cycleDone = 1'b0;
   wire  scl;
   wire  sda;
   logic slvSdaLow = 1'b0;

   pullup (scl);
   pullup (sda);
   assign sda = slvSdaLow ? 1'b0 : 1'bz;

   i2c_unit_if bus ();

   i2c_unit dut (
      .clk       (clk),
      .reset     (reset),
      .cycleDone (cycleDone),
      .bus       (bus),
      .i2cScl    (scl),
      .i2cSda    (sda)
   );

   always #5 clk = ~clk;

   // Irregular quarter-bit ticks, changed shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      cycleDone = ($urandom_range(0, 2) == 0);
   end

   int nChecks = 0;
   int nErrors = 0;

   task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   int wdAckCnt = 0;
   int rdValidCnt = 0;
   always @(negedge clk) begin
      if (bus.i2cWriteDataAck === 1'b1) wdAckCnt++;
      if (bus.i2cReadDataValid === 1'b1) rdValidCnt++;
   end

   // Bus monitor plus 24LC00-style slave (16 bytes, control 1010xxxR, write committed at STOP).
   logic       pScl = 1'b1, pSda = 1'b1;
   logic       sclV, sdaV;
   int         monStarts = 0, monStops = 0, monCnt = 0;
   logic [7:0] monShift = 8'h00, monByte = 8'h00;
   logic       monAck = 1'b1;
   bit         slvPresent = 1'b1;
   bit         slvActive = 1'b0, slvTx = 1'b0, slvRise = 1'b0;
   bit         slvAckMine = 1'b0, slvNack = 1'b0, slvPend = 1'b0;
   int         slvPhase = 0, slvBit = 0, slvBusy = 0;
   logic [7:0] slvShift = 8'h00, slvTxByte = 8'h00, slvPendData = 8'h00;
   logic [3:0] slvPtr = 4'h0, slvPendAddr = 4'h0;
   logic       slvMAck = 1'b1;
   logic [7:0] eeMem [16];

   always @(negedge clk) begin
      sclV = (scl !== 1'b0);
      sdaV = (sda !== 1'b0);
      if (slvBusy > 0) slvBusy--;
      if (sclV && pScl && pSda && !sdaV) begin
         monStarts++;
         monCnt    = 0;
         slvActive = slvPresent;
         slvPhase  = 0;
         slvBit    = 0;
         slvRise   = 1'b0;
         slvTx     = 1'b0;
         slvSdaLow = 1'b0;
      end else if (sclV && pScl && !pSda && sdaV) begin
         monStops++;
         slvActive = 1'b0;
         slvRise   = 1'b0;
         slvTx     = 1'b0;
         slvSdaLow = 1'b0;
         if (slvPend) begin
            eeMem[slvPendAddr] = slvPendData;
            slvPend = 1'b0;
            slvBusy = 500;
         end
      end else if (sclV && !pScl) begin
         if (monCnt < 8) begin
            monShift = {monShift[6:0], sdaV};
            monCnt++;
            if (monCnt == 8) monByte = monShift;
         end else begin
            monAck = sdaV;
            monCnt = 0;
         end
         slvRise = 1'b1;
         if (slvActive) begin
            if (slvBit < 8) slvShift = {slvShift[6:0], sdaV};
            else slvMAck = sdaV;
         end
      end else if (!sclV && pScl && slvRise) begin
         slvRise = 1'b0;
         if (slvActive) begin
            if (slvBit == 7) begin
               slvBit = 8;
               if (slvTx) begin
                  slvSdaLow  = 1'b0;
                  slvAckMine = 1'b0;
               end else begin
                  slvAckMine = 1'b1;
                  slvNack    = 1'b0;
                  if (slvPhase == 0) begin
                     if (slvShift[7:4] == 4'hA && slvBusy == 0) begin
                        if (slvShift[0]) slvTx = 1'b1;
                        else slvPhase = 1;
                     end else begin
                        slvNack = 1'b1;
                     end
                  end else if (slvPhase == 1) begin
                     slvPtr   = slvShift[3:0];
                     slvPhase = 2;
                  end else begin
                     slvPendAddr = slvPtr;
                     slvPendData = slvShift;
                     slvPend     = 1'b1;
                     slvPtr      = slvPtr + 4'd1;
                  end
                  slvSdaLow = !slvNack;
               end
            end else if (slvBit == 8) begin
               slvBit    = 0;
               slvSdaLow = 1'b0;
               if (slvAckMine && slvNack) begin
                  slvActive = 1'b0;
               end else if (slvTx && (slvAckMine || !slvMAck)) begin
                  slvTxByte = eeMem[slvPtr];
                  slvPtr    = slvPtr + 4'd1;
                  slvSdaLow = !slvTxByte[7];
               end else if (slvTx) begin
                  slvTx     = 1'b0;
                  slvActive = 1'b0;
               end
            end else begin
               slvBit++;
               if (slvTx) slvSdaLow = !slvTxByte[7 - slvBit];
            end
         end
      end
      pScl = sclV;
      pSda = sdaV;
   end

   // Issue one command and wait for it to finish; ticks counts the bus ticks it consumed.
   // With spoil set, valid stays high with a different command for most of the busy period.
   task automatic runCmd(input logic [1:0] cmd, input logic [7:0] wd, input logic wa,
                         input bit spoil, output int ticks);
      int guard;
      @(negedge clk);
      bus.i2cCommand          = cmd;
      bus.i2cWriteData        = wd;
      bus.i2cWriteAck         = wa;
      bus.i2cTransactionValid = 1'b1;
      guard = 0;
      while (!cycleDone && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      expectEq("accept wait", 32'(guard >= 100), 32'd0);
      ticks = 1;
      @(negedge clk);
      expectEq("busy rise", 32'(bus.i2cBusy), 32'd1);
      if (spoil) begin
         bus.i2cCommand   = ~cmd;
         bus.i2cWriteData = ~wd;
      end else begin
         bus.i2cTransactionValid = 1'b0;
      end
      guard = 0;
      while (bus.i2cBusy && guard < 1000) begin
         if (cycleDone) ticks++;
         @(negedge clk);
         guard++;
         if (spoil && ticks >= 20) bus.i2cTransactionValid = 1'b0;
      end
      bus.i2cTransactionValid = 1'b0;
      expectEq("busy wait", 32'(guard >= 1000), 32'd0);
      @(negedge clk);
   endtask

   task automatic pollCtrl(input logic [7:0] ctrl);
      int t;
      int n;
      n = 0;
      do begin
         runCmd(CMD_START, 8'h00, 1'b1, 1'b0, t);
         runCmd(CMD_TX, ctrl, 1'b1, 1'b0, t);
         n++;
         if (bus.i2cReadAck) runCmd(CMD_STOP, 8'h00, 1'b1, 1'b0, t);
      end while (bus.i2cReadAck && n < 20);
      expectEq("poll ack", 32'(bus.i2cReadAck), 32'd0);
   endtask

   logic [7:0] refMem [16];

   task automatic eeWrite(input logic [3:0] addr, input logic [7:0] data);
      int t;
      pollCtrl(8'hA0);
      runCmd(CMD_TX, {4'h0, addr}, 1'b1, 1'b0, t);
      expectEq("wr addr ack", 32'(bus.i2cReadAck), 32'd0);
      runCmd(CMD_TX, data, 1'b1, 1'b0, t);
      expectEq("wr data ticks", 32'(t), 32'd36);
      expectEq("wr data bus", 32'(monByte), 32'(data));
      expectEq("wr data ack", 32'(bus.i2cReadAck), 32'd0);
      runCmd(CMD_STOP, 8'h00, 1'b1, 1'b0, t);
   endtask

   task automatic eeRead(input logic [3:0] addr);
      int t;
      int rv0;
      pollCtrl(8'hA0);
      runCmd(CMD_TX, {4'h0, addr}, 1'b1, 1'b0, t);
      expectEq("rd addr ack", 32'(bus.i2cReadAck), 32'd0);
      runCmd(CMD_START, 8'h00, 1'b1, 1'b0, t);
      runCmd(CMD_TX, 8'hA1, 1'b1, 1'b0, t);
      expectEq("rd ctrl ack", 32'(bus.i2cReadAck), 32'd0);
      rv0 = rdValidCnt;
      runCmd(CMD_RX, 8'h00, 1'b1, 1'b0, t);
      expectEq("rx ticks", 32'(t), 32'd36);
      expectEq("rx data", 32'(bus.i2cReadData), 32'(refMem[addr]));
      expectEq("rx valid pulses", 32'(rdValidCnt - rv0), 32'd1);
      expectEq("rx master nack", 32'(monAck), 32'd1);
      runCmd(CMD_STOP, 8'h00, 1'b1, 1'b0, t);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int g;
      int st0;
      int sp0;
      int wd0;
      bus.i2cCommand          = CMD_START;
      bus.i2cWriteData        = 8'h00;
      bus.i2cWriteAck         = 1'b1;
      bus.i2cTransactionValid = 1'b0;

      reset = 1'b0;
      repeat (10) @(negedge clk);
      expectEq("rst scl", 32'(scl), 32'd1);
      expectEq("rst sda", 32'(sda), 32'd1);
      expectEq("rst busy", 32'(bus.i2cBusy), 32'd0);
      expectEq("rst readAck", 32'(bus.i2cReadAck), 32'd1);
      expectEq("rst readData", 32'(bus.i2cReadData), 32'd0);
      expectEq("rst wdAck", 32'(bus.i2cWriteDataAck), 32'd0);
      expectEq("rst rdValid", 32'(bus.i2cReadDataValid), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // START + control byte to an idle EEPROM
      st0 = monStarts;
      runCmd(CMD_START, 8'h00, 1'b1, 1'b0, t);
      expectEq("start ticks", 32'(t), 32'd4);
      expectEq("start seen", 32'(monStarts - st0), 32'd1);
      expectEq("start scl held", 32'(scl), 32'd0);
      wd0 = wdAckCnt;
      runCmd(CMD_TX, 8'hA0, 1'b1, 1'b0, t);
      expectEq("tx ticks", 32'(t), 32'd36);
      expectEq("tx bus byte", 32'(monByte), 32'hA0);
      expectEq("tx ack", 32'(bus.i2cReadAck), 32'd0);
      expectEq("tx wdAck pulses", 32'(wdAckCnt - wd0), 32'd1);
      sp0 = monStops;
      runCmd(CMD_STOP, 8'h00, 1'b1, 1'b0, t);
      expectEq("stop ticks", 32'(t), 32'd4);
      expectEq("stop seen", 32'(monStops - sp0), 32'd1);
      expectEq("stop scl", 32'(scl), 32'd1);
      expectEq("stop sda", 32'(sda), 32'd1);

      // No slave answering
      slvPresent = 1'b0;
      runCmd(CMD_START, 8'h00, 1'b1, 1'b0, t);
      runCmd(CMD_TX, 8'hA0, 1'b1, 1'b0, t);
      expectEq("noslave ack", 32'(bus.i2cReadAck), 32'd1);
      runCmd(CMD_STOP, 8'h00, 1'b1, 1'b0, t);
      slvPresent = 1'b1;

      for (int a = 0; a < 16; a++) begin
         refMem[a] = 8'($urandom);
         eeWrite(4'(a), refMem[a]);
      end
      for (int a = 0; a < 16; a++) eeRead(4'(a));

      // Requests while busy are ignored
      pollCtrl(8'hA0);
      runCmd(CMD_STOP, 8'h00, 1'b1, 1'b0, t);
      runCmd(CMD_START, 8'h00, 1'b1, 1'b0, t);
      wd0 = wdAckCnt;
      runCmd(CMD_TX, 8'hA0, 1'b1, 1'b1, t);
      expectEq("spoil ticks", 32'(t), 32'd36);
      expectEq("spoil bus byte", 32'(monByte), 32'hA0);
      expectEq("spoil ack", 32'(bus.i2cReadAck), 32'd0);
      expectEq("spoil wdAck pulses", 32'(wdAckCnt - wd0), 32'd1);
      repeat (20) @(negedge clk);
      expectEq("spoil stays idle", 32'(bus.i2cBusy), 32'd0);
      runCmd(CMD_STOP, 8'h00, 1'b1, 1'b0, t);

      // Reset during bit 4 of a transmit
      runCmd(CMD_START, 8'h00, 1'b1, 1'b0, t);
      @(negedge clk);
      bus.i2cCommand          = CMD_TX;
      bus.i2cWriteData        = 8'h55;
      bus.i2cTransactionValid = 1'b1;
      g = 0;
      while (!cycleDone && g < 100) begin
         @(negedge clk);
         g++;
      end
      t = 1;
      @(negedge clk);
      bus.i2cTransactionValid = 1'b0;
      g = 0;
      while (t < 18 && g < 1000) begin
         if (cycleDone) t++;
         @(negedge clk);
         g++;
      end
      expectEq("mid scl high", 32'(scl), 32'd1);
      expectEq("mid sda bit4", 32'(sda), 32'd0);
      reset = 1'b0;
      #1;
      expectEq("abort scl", 32'(scl), 32'd1);
      expectEq("abort sda", 32'(sda), 32'd1);
      expectEq("abort busy", 32'(bus.i2cBusy), 32'd0);
      expectEq("abort readData", 32'(bus.i2cReadData), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      st0 = monStarts;
      runCmd(CMD_START, 8'h00, 1'b1, 1'b0, t);
      expectEq("post-rst start ticks", 32'(t), 32'd4);
      expectEq("post-rst start seen", 32'(monStarts - st0), 32'd1);
      runCmd(CMD_STOP, 8'h00, 1'b1, 1'b0, t);
      expectEq("final scl", 32'(scl), 32'd1);
      expectEq("final sda", 32'(sda), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end
endmodule
